fifo_alu_sequencer: RTL

Sequencer between the UART receive FIFO, the ALU and the UART transmit FIFO. It pops three words from the RX FIFO (operand A, operand B, opcode), presents them to the ALU, and pushes the registered ALU result into the TX FIFO. It is the only master of both FIFOs' read/write strobes in the UART–ALU top level. It also keeps completed-operation and illegal-opcode counters for debug.

---
 rtl/fifo_alu_sequencer.sv | 111 +++++++++++
 1 files changed

// File: rtl/fifo_alu_sequencer.sv
// Pops operand A, operand B and an opcode from the RX FIFO, drives the ALU, and
// pushes the registered ALU result to the TX FIFO. Keeps debug counters.
module fifo_alu_sequencer #(
    parameter int WORD_SIZE = 8,
    parameter int OP_SIZE   = 6,
    parameter int CNT_SIZE  = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_rx_empty,
    input  logic [WORD_SIZE-1:0] i_rx_data,
    output logic                 o_rx_read,
    input  logic                 i_tx_full,
    output logic                 o_tx_write,
    output logic [WORD_SIZE-1:0] o_tx_data,
    output logic [WORD_SIZE-1:0] o_alu_a,
    output logic [WORD_SIZE-1:0] o_alu_b,
    output logic [OP_SIZE-1:0]   o_alu_op,
    input  logic [WORD_SIZE-1:0] i_alu_result,
    output logic                 o_busy,
    output logic [CNT_SIZE-1:0]  o_ops_done,
    output logic [CNT_SIZE-1:0]  o_op_errors
);

    localparam logic [2:0] POP_A   = 3'd0;
    localparam logic [2:0] WAIT_A  = 3'd1;
    localparam logic [2:0] POP_B   = 3'd2;
    localparam logic [2:0] WAIT_B  = 3'd3;
    localparam logic [2:0] POP_OP  = 3'd4;
    localparam logic [2:0] WAIT_OP = 3'd5;
    localparam logic [2:0] EXEC    = 3'd6;
    localparam logic [2:0] PUSH    = 3'd7;

    // ADD, SUB, AND, OR, XOR, NOR, SRA, SRL; compared against the full opcode word.
    localparam int NUM_OPS = 8;
    localparam logic [8*NUM_OPS-1:0] LEGAL_OPS =
        {8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27, 8'h03, 8'h02};

    localparam logic [CNT_SIZE-1:0] CNT_ONE = {{(CNT_SIZE-1){1'b0}}, 1'b1};

    logic [2:0]           state_reg, state_next;
    logic [WORD_SIZE-1:0] alu_a_reg, alu_b_reg, tx_data_reg;
    logic [OP_SIZE-1:0]   alu_op_reg;
    logic [CNT_SIZE-1:0]  ops_done_reg, op_errors_reg;
    logic [NUM_OPS-1:0]   op_match;
    logic                 op_legal;
    logic                 pop_state;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_OPS; gi++) begin : g_op_match
            assign op_match[gi] = (i_rx_data == WORD_SIZE'(LEGAL_OPS[gi*8 +: 8]));
        end
    endgenerate

    assign op_legal  = |op_match;
    assign pop_state = (state_reg == POP_A) || (state_reg == POP_B) || (state_reg == POP_OP);

    // Strobes are combinational so a read/write is issued in the same cycle the flag allows it.
    assign o_rx_read  = !i_rst && pop_state && !i_rx_empty;
    assign o_tx_write = !i_rst && (state_reg == PUSH) && !i_tx_full;

    assign o_busy      = (state_reg != POP_A);
    assign o_alu_a     = alu_a_reg;
    assign o_alu_b     = alu_b_reg;
    assign o_alu_op    = alu_op_reg;
    assign o_tx_data   = tx_data_reg;
    assign o_ops_done  = ops_done_reg;
    assign o_op_errors = op_errors_reg;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            POP_A:   if (!i_rx_empty) state_next = WAIT_A;
            WAIT_A:  state_next = POP_B;
            POP_B:   if (!i_rx_empty) state_next = WAIT_B;
            WAIT_B:  state_next = POP_OP;
            POP_OP:  if (!i_rx_empty) state_next = WAIT_OP;
            WAIT_OP: state_next = op_legal ? EXEC : POP_A;
            EXEC:    state_next = PUSH;
            PUSH:    if (!i_tx_full) state_next = POP_A;
            default: state_next = POP_A;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg     <= POP_A;
            alu_a_reg     <= '0;
            alu_b_reg     <= '0;
            alu_op_reg    <= '0;
            tx_data_reg   <= '0;
            ops_done_reg  <= '0;
            op_errors_reg <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                WAIT_A: alu_a_reg <= i_rx_data;
                WAIT_B: alu_b_reg <= i_rx_data;
                WAIT_OP: begin
                    alu_op_reg <= i_rx_data[OP_SIZE-1:0];
                    if (!op_legal) op_errors_reg <= op_errors_reg + CNT_ONE;
                end
                EXEC: tx_data_reg <= i_alu_result;
                PUSH: if (!i_tx_full) ops_done_reg <= ops_done_reg + CNT_ONE;
                default: ;
            endcase
        end
    end

endmodule
